// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculator command sequencer.
// Holds the command and calculator-bus layouts, ALU opcode constants,
// the sequencer state enum and helpers that build calculator bus words.
package calc_seq_pkg;

    localparam int unsigned CMD_W     = 12;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned CTRL_W    = 3;
    localparam int unsigned DEF_DEPTH = 4;

    // ALU opcodes; 3'b011 is undefined and makes the ALU produce 0
    localparam logic [CTRL_W-1:0] OP_AND  = 3'b000;
    localparam logic [CTRL_W-1:0] OP_OR   = 3'b001;
    localparam logic [CTRL_W-1:0] OP_ADD  = 3'b010;
    localparam logic [CTRL_W-1:0] OP_ANDN = 3'b100;
    localparam logic [CTRL_W-1:0] OP_ORN  = 3'b101;
    localparam logic [CTRL_W-1:0] OP_SUB  = 3'b110;
    localparam logic [CTRL_W-1:0] OP_SLT  = 3'b111;
    localparam logic [CTRL_W-1:0] OP_NOP  = OP_OR;

    // Command word: [11]=readback [10:8]=control [7:6]=we_addr [5:4]=rd_addr [3:0]=immediate
    typedef struct packed {
        logic              readback;
        logic [CTRL_W-1:0] control;
        logic [ADDR_W-1:0] we_addr;
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] immediate;
    } cmd_t;

    // Fields driven towards the calculator each cycle
    typedef struct packed {
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] immediate;
        logic [ADDR_W-1:0] we_addr;
        logic [CTRL_W-1:0] control;
    } calc_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RB,
        ST_RSP
    } state_e;

    // reg[a] <= reg[a] | 0 : keeps the calculator's every-negedge write harmless
    function automatic calc_bus_t nop_bus(input logic [ADDR_W-1:0] addr);
        calc_bus_t b;
        b.rd_addr   = addr;
        b.immediate = '0;
        b.we_addr   = addr;
        b.control   = OP_NOP;
        return b;
    endfunction

    function automatic calc_bus_t cmd_bus(input cmd_t c);
        calc_bus_t b;
        b.rd_addr   = c.rd_addr;
        b.immediate = c.immediate;
        b.we_addr   = c.we_addr;
        b.control   = c.control;
        return b;
    endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// Command and response streams of the calculator command sequencer.
//   cmd_valid/cmd_ready/cmd_data : 12-bit command stream into the sequencer
//   rsp_valid/rsp_ready/rsp_data/rsp_addr : readback results out of the sequencer
// master = command producer / response consumer, slave = the sequencer.
interface calc_cmd_sequencer_if;
    import calc_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr
    );

endinterface

// File: rtl/calc_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO with synchronous active-high reset.
//   push/push_data : write when not full
//   pop/head_data  : head_data shows the oldest entry; pop removes it when not empty
//   count/empty/full : registered occupancy and flags
module calc_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            empty <= (count_d == CNT_W'(0));
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Feeds the 4-bit calculator from a buffered command stream.
//   clk, rst       : single clock, synchronous active-high reset
//   bus (slave)    : cmd_valid/cmd_ready/cmd_data in, rsp_valid/rsp_ready/rsp_data/rsp_addr out
//   calc_*         : registered rd_addr/immediate/we_addr/control to the calculator
//   calc_rd_data   : combinational register read from the calculator
//   busy           : sequencer not idle or commands still queued
//   fifo_count     : command FIFO occupancy
// One command is issued per cycle; any cycle without a command carries a NOP
// that rewrites a register with its own value, since the calculator writes
// on every falling edge.
module calc_cmd_sequencer
    import calc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    calc_cmd_sequencer_if.slave    bus,
    output logic [ADDR_W-1:0]      calc_rd_addr,
    output logic [DATA_W-1:0]      calc_immediate,
    output logic [ADDR_W-1:0]      calc_we_addr,
    output logic [CTRL_W-1:0]      calc_control,
    input  logic [DATA_W-1:0]      calc_rd_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    calc_bus_t         calc_q, calc_d;
    cmd_t              entry_q, entry_d;
    cmd_t              head;
    logic [CMD_W-1:0]  head_raw;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              busy_q, busy_d;
    logic              push, pop, load;
    logic              fifo_empty, fifo_full;

    // Ready reflects only the registered full flag: no bypass when full
    assign push          = bus.cmd_valid & ~fifo_full;
    assign head          = cmd_t'(head_raw);
    assign bus.cmd_ready = ~fifo_full;

    calc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.cmd_data),
        .pop       (pop),
        .head_data (head_raw),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        calc_d      = calc_q;
        entry_d     = entry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        load        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    calc_d = nop_bus(calc_q.we_addr);
                end
            end
            ST_EXEC: begin
                if (entry_q.readback) begin
                    calc_d  = nop_bus(entry_q.we_addr);
                    state_d = ST_RB;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    calc_d  = nop_bus(entry_q.we_addr);
                    state_d = ST_IDLE;
                end
            end
            // The NOP issued on entry re-reads we_addr, so rd_data is the written value
            ST_RB: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = calc_rd_data;
                rsp_addr_d  = entry_q.we_addr;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            pop     = 1'b1;
            entry_d = head;
            calc_d  = cmd_bus(head);
            state_d = ST_EXEC;
        end

        // Queue is non-empty after this edge if something arrives or more remains than leaves
        busy_d = (state_d != ST_IDLE) || push || (fifo_count > CNT_W'(pop));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            calc_q      <= nop_bus(ADDR_W'(0));
            entry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            calc_q      <= calc_d;
            entry_q     <= entry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign calc_rd_addr   = calc_q.rd_addr;
    assign calc_immediate = calc_q.immediate;
    assign calc_we_addr   = calc_q.we_addr;
    assign calc_control   = calc_q.control;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_addr   = rsp_addr_q;
    assign busy           = busy_q;

endmodule
